// File: rtl/ddr3_init_refresh.sv
// DDR3 power-up initialisation sequencer plus periodic auto-refresh engine.
// Owns the command pins until init completes, then borrows them per refresh.
module ddr3_init_refresh #(
  parameter int BA_BITS      = 3,
  parameter int ADDR_BITS    = 14,
  parameter int T_RESET      = 80000,
  parameter int T_CKE        = 200000,
  parameter int T_XPR        = 48,
  parameter int T_MRD        = 4,
  parameter int T_MOD        = 12,
  parameter int T_ZQINIT     = 512,
  parameter int T_REFI       = 3120,
  parameter int T_RFC        = 44,
  parameter int MAX_POSTPONE = 8,
  parameter logic [ADDR_BITS-1:0] MR0 = '0,
  parameter logic [ADDR_BITS-1:0] MR1 = '0,
  parameter logic [ADDR_BITS-1:0] MR2 = '0,
  parameter logic [ADDR_BITS-1:0] MR3 = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ddr_rst_n,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 odt,
  output logic                 cmd_own,
  output logic                 init_done,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic [3:0]           ref_pending
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_RESET, T_CKE), max2(T_XPR, T_MRD)),
                              max2(max2(T_MOD, T_ZQINIT), max2(T_REFI, T_RFC)));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] PEND_MAX = 4'(MAX_POSTPONE);

  // Each wait state issues the next command when its countdown hits zero.
  typedef enum logic [3:0] {
    S_RST_HOLD, S_CKE_WAIT, S_XPR, S_MRS3, S_MRS1, S_MRS0,
    S_MOD_WAIT, S_ZQ_WAIT, S_IDLE, S_RFC_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       refi_q, refi_d;
  logic [3:0]             pend_q, pend_d;
  logic [3:0]             cmd_q, cmd_d;
  logic [BA_BITS-1:0]     ba_q, ba_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   ddr_rst_n_q, ddr_rst_n_d;
  logic                   cke_q, cke_d;
  logic                   own_q, own_d;
  logic                   done_q, done_d;
  logic                   req_q, req_d;
  logic                   cnt_zero, refi_exp, issue_ref;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    cmd_d       = CMD_NOP;
    ba_d        = '0;
    addr_d      = '0;
    ddr_rst_n_d = ddr_rst_n_q;
    cke_d       = cke_q;
    own_d       = own_q;
    done_d      = done_q;
    cnt_zero    = (cnt_q == '0);
    issue_ref   = 1'b0;

    // Refresh interval timer free-runs once init has finished.
    refi_exp = done_q && (refi_q == '0);
    refi_d   = refi_q;
    if (done_q) refi_d = refi_exp ? CNT_W'(T_REFI - 1) : refi_q - CNT_W'(1);

    unique case (state_q)
      S_RST_HOLD: if (cnt_zero) begin
        ddr_rst_n_d = 1'b1;
        cnt_d       = CNT_W'(T_CKE - 1);
        state_d     = S_CKE_WAIT;
      end
      S_CKE_WAIT: if (cnt_zero) begin
        cke_d   = 1'b1;
        cnt_d   = CNT_W'(T_XPR - 1);
        state_d = S_XPR;
      end
      S_XPR: if (cnt_zero) begin
        cmd_d   = CMD_MRS;
        ba_d    = BA_BITS'(2);
        addr_d  = MR2;
        cnt_d   = CNT_W'(T_MRD - 1);
        state_d = S_MRS3;
      end
      S_MRS3: if (cnt_zero) begin
        cmd_d   = CMD_MRS;
        ba_d    = BA_BITS'(3);
        addr_d  = MR3;
        cnt_d   = CNT_W'(T_MRD - 1);
        state_d = S_MRS1;
      end
      S_MRS1: if (cnt_zero) begin
        cmd_d   = CMD_MRS;
        ba_d    = BA_BITS'(1);
        addr_d  = MR1;
        cnt_d   = CNT_W'(T_MRD - 1);
        state_d = S_MRS0;
      end
      S_MRS0: if (cnt_zero) begin
        cmd_d   = CMD_MRS;
        ba_d    = BA_BITS'(0);
        addr_d  = MR0;
        cnt_d   = CNT_W'(T_MOD - 1);
        state_d = S_MOD_WAIT;
      end
      S_MOD_WAIT: if (cnt_zero) begin
        cmd_d      = CMD_ZQCL;
        addr_d[10] = 1'b1;
        cnt_d      = CNT_W'(T_ZQINIT - 1);
        state_d    = S_ZQ_WAIT;
      end
      S_ZQ_WAIT: if (cnt_zero) begin
        done_d  = 1'b1;
        own_d   = 1'b0;
        refi_d  = CNT_W'(T_REFI - 1);
        state_d = S_IDLE;
      end
      S_IDLE: issue_ref = req_q && bus_gnt;
      // A grant sampled on the last RFC cycle chains the next REF with no bus gap.
      S_RFC_WAIT: if (cnt_zero) begin
        if (req_q && bus_gnt) begin
          issue_ref = 1'b1;
        end else begin
          own_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RST_HOLD;
    endcase

    if (issue_ref) begin
      cmd_d   = CMD_REF;
      own_d   = 1'b1;
      cnt_d   = CNT_W'(T_RFC - 1);
      state_d = S_RFC_WAIT;
    end

    // Request rises only from IDLE; during RFC it can only hold or drop.
    if (issue_ref)                 req_d = 1'b1;
    else if (state_q == S_IDLE)    req_d = (pend_q != '0);
    else if (state_q == S_RFC_WAIT) req_d = req_q && (pend_q != '0);
    else                           req_d = 1'b0;

    pend_d = pend_q;
    if (refi_exp && !issue_ref) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + 4'd1;
    end else if (issue_ref && !refi_exp) begin
      pend_d = pend_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_HOLD;
      cnt_q       <= CNT_W'(T_RESET - 1);
      refi_q      <= '0;
      pend_q      <= '0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      addr_q      <= '0;
      ddr_rst_n_q <= 1'b0;
      cke_q       <= 1'b0;
      own_q       <= 1'b1;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      refi_q      <= refi_d;
      pend_q      <= pend_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      ddr_rst_n_q <= ddr_rst_n_d;
      cke_q       <= cke_d;
      own_q       <= own_d;
      done_q      <= done_d;
      req_q       <= req_d;
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign ba          = ba_q;
  assign addr        = addr_q;
  assign ddr_rst_n   = ddr_rst_n_q;
  assign cke         = cke_q;
  assign odt         = 1'b0;
  assign cmd_own     = own_q;
  assign init_done   = done_q;
  assign bus_req     = req_q;
  assign ref_pending = pend_q;

endmodule

// File: tb/tb_ddr3_init_refresh.sv
// Bench for ddr3_init_refresh: constant init timeline plus a time-stamp based
// refresh model (expiry times, busy window, pending count) checked every cycle.
module tb_ddr3_init_refresh;
  localparam int TR = 10, TC = 20, TX = 5, TM = 4, TMOD = 12, TZQ = 16;
  localparam int TREFI = 50, TRFC = 6, MAXP = 8;
  localparam logic [13:0] M0 = 14'h0D70, M1 = 14'h0044, M2 = 14'h0218, M3 = 14'h0003;
  localparam int E_CKE = TR + TC, E_MR2 = E_CKE + TX, E_MR0 = E_MR2 + 3 * TM;
  localparam int E_ZQ = E_MR0 + TMOD, E_DONE = E_ZQ + TZQ;
  localparam logic [3:0] NOP = 4'b0111, REF = 4'b0001;
  localparam logic [30:0] RST_EXP = {1'b0, 1'b0, NOP, 3'd0, 14'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};

  logic clk = 1'b0, rst_n = 1'b0, bus_gnt = 1'b0;
  logic ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt, cmd_own, init_done, bus_req;
  logic [2:0] ba;
  logic [13:0] addr;
  logic [3:0] ref_pending;
  int total = 0, bad = 0;

  ddr3_init_refresh #(
    .BA_BITS(3), .ADDR_BITS(14), .T_RESET(TR), .T_CKE(TC), .T_XPR(TX), .T_MRD(TM),
    .T_MOD(TMOD), .T_ZQINIT(TZQ), .T_REFI(TREFI), .T_RFC(TRFC), .MAX_POSTPONE(MAXP),
    .MR0(M0), .MR1(M1), .MR2(M2), .MR3(M3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ddr_rst_n(ddr_rst_n), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .odt(odt),
    .cmd_own(cmd_own), .init_done(init_done), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .ref_pending(ref_pending)
  );

  always #5 clk = ~clk;

  wire [3:0]  cmd      = {cs_n, ras_n, cas_n, we_n};
  wire [30:0] rst_vec  = {ddr_rst_n, cke, cmd, ba, addr, odt, cmd_own, init_done, bus_req, ref_pending};
  wire [24:0] init_vec = {ddr_rst_n, cke, cmd, ba, addr, cmd_own, init_done};
  wire [9:0]  dut_vec  = {cmd_own, cmd, bus_req, ref_pending};

  // Reference model: n = clock edges since reset release.
  int n = 0, m_pend = 0, busy_end = 0;
  bit m_req = 1'b0, m_ref = 1'b0;

  function automatic bit is_exp(input int c);
    return (c > E_DONE) && (((c - E_DONE) % TREFI) == 0);
  endfunction

  function automatic logic [9:0] model_vec();
    return {(n < E_DONE) || (n < busy_end), m_ref ? REF : NOP, m_req, 4'(m_pend)};
  endfunction

  initial begin
    int p_old;
    bit e, pre_busy;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; m_pend = 0; m_req = 1'b0; busy_end = 0; m_ref = 1'b0;
      end else begin
        n++;
        m_ref = 1'b0;
        if (n > E_DONE) begin
          e        = is_exp(n);
          pre_busy = (n <= busy_end);
          p_old    = m_pend;
          m_ref    = (n >= busy_end) && m_req && bus_gnt;
          if (e && !m_ref) begin
            if (m_pend < MAXP) m_pend++;
          end else if (m_ref && !e) begin
            m_pend--;
          end
          if (m_ref) begin
            busy_end = n + TRFC;
            m_req    = 1'b1;
          end else begin
            m_req = pre_busy ? (m_req && p_old != 0) : (p_old != 0);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; bus_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rst_vec !== RST_EXP) begin
      bad++; $display("FAIL reset_values got=%h exp=%h", rst_vec, RST_EXP);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_init(input string tag);
    int order [4] = '{2, 3, 1, 0};
    logic [3:0] ec;
    logic [2:0] eb;
    logic [13:0] ea;
    logic [24:0] ev;
    for (int k = 1; k <= E_DONE + 2; k++) begin
      @(posedge clk); #1;
      ec = NOP; eb = '0; ea = '0;
      for (int j = 0; j < 4; j++) begin
        if (k == E_MR2 + j * TM) begin
          ec = 4'b0000;
          eb = 3'(order[j]);
          case (order[j])
            0: ea = M0;
            1: ea = M1;
            2: ea = M2;
            default: ea = M3;
          endcase
        end
      end
      if (k == E_ZQ) begin ec = 4'b0110; ea = 14'h0400; end
      ev = {k >= TR, k >= E_CKE, ec, eb, ea, k < E_DONE, k >= E_DONE};
      total++;
      if (init_vec !== ev) begin
        bad++; $display("FAIL init_%s cycle=%0d got=%h exp=%h", tag, k, init_vec, ev);
      end
      @(negedge clk) bus_gnt = 1'($urandom_range(0, 1));
    end
    bus_gnt = 1'b0;
  endtask

  task automatic test_gnt_high();
    int refs = 0, own_cyc = 0, peak = 0;
    bus_gnt = 1'b1;
    while (n < 300) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL gnt_high n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
      if (cmd === REF) refs++;
      if (cmd_own === 1'b1) own_cyc++;
      if (int'(ref_pending) > peak) peak = int'(ref_pending);
    end
    total++;
    if (refs != 4) begin bad++; $display("FAIL gnt_high_refs got=%0d exp=4", refs); end
    total++;
    if (own_cyc != 4 * TRFC) begin
      bad++; $display("FAIL gnt_high_own got=%0d exp=%0d", own_cyc, 4 * TRFC);
    end
    total++;
    if (peak != 1) begin bad++; $display("FAIL gnt_high_peak got=%0d exp=1", peak); end
    @(negedge clk) bus_gnt = 1'b0;
  endtask

  task automatic test_postpone5();
    int refs = 0, last = -1;
    bit found = 1'b0, done = 1'b0;
    for (int c = 0; c < 8 * TREFI && !found; c++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL postpone_hold n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
      if (is_exp(n) && m_pend == 5) found = 1'b1;
    end
    total++;
    if (!found || ref_pending !== 4'd5) begin
      bad++; $display("FAIL postpone_count got=%0d exp=5", ref_pending);
    end
    @(negedge clk) bus_gnt = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL postpone_drain n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
      if (cmd === REF) begin
        if (last >= 0) begin
          total++;
          if (n - last != TRFC) begin
            bad++; $display("FAIL postpone_spacing got=%0d exp=%0d", n - last, TRFC);
          end
        end
        last = n; refs++;
      end
      if (bus_req === 1'b0 && cmd_own === 1'b0) done = 1'b1;
    end
    total++;
    if (!done || refs != 5) begin
      bad++; $display("FAIL postpone_refs got=%0d exp=5 drained=%0d", refs, done);
    end
    @(negedge clk) bus_gnt = 1'b0;
  endtask

  task automatic test_saturate();
    int refs = 0;
    bit found = 1'b0, done = 1'b0;
    repeat (12 * TREFI) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL sat_hold n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
    end
    for (int c = 0; c <= TREFI && !found; c++) begin
      @(posedge clk); #1;
      if (is_exp(n)) found = 1'b1;
    end
    total++;
    if (!found || ref_pending !== 4'(MAXP) || bus_req !== 1'b1) begin
      bad++; $display("FAIL sat_count got=%0d req=%b exp=%0d", ref_pending, bus_req, MAXP);
    end
    @(negedge clk) bus_gnt = 1'b1;
    for (int c = 0; c < 150 && !done; c++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL sat_drain n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
      if (cmd === REF) refs++;
      if (bus_req === 1'b0 && cmd_own === 1'b0) done = 1'b1;
    end
    total++;
    if (!done || refs != MAXP) begin
      bad++; $display("FAIL sat_refs got=%0d exp=%0d drained=%0d", refs, MAXP, done);
    end
    @(negedge clk) bus_gnt = 1'b0;
  endtask

  task automatic test_coincide();
    int e1 = 0;
    bit found = 1'b0;
    for (int c = 0; c < 2 * TREFI && !found; c++) begin
      @(posedge clk); #1;
      if (is_exp(n) && m_pend >= 1) found = 1'b1;
    end
    e1 = n + TREFI;
    for (int c = 0; c < 2 * TREFI && n < e1 - 1; c++) begin
      @(posedge clk); #1;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL coincide_wait n=%0d got=%h exp=%h", n, dut_vec, model_vec());
      end
    end
    @(negedge clk) bus_gnt = 1'b1;
    @(posedge clk); #1;
    total++;
    if (!found || !is_exp(n) || cmd !== REF || ref_pending !== 4'd1) begin
      bad++; $display("FAIL coincide cmd=%h pend=%0d exp_cmd=%h exp_pend=1", cmd, ref_pending, REF);
    end
    @(negedge clk) bus_gnt = 1'b0;
  endtask

  task automatic test_rst_mid_rfc();
    bit seen = 1'b0;
    bus_gnt = 1'b1;
    for (int c = 0; c < 2 * TREFI && !seen; c++) begin
      @(posedge clk); #1;
      if (cmd === REF) seen = 1'b1;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (!seen || rst_vec !== RST_EXP) begin
      bad++; $display("FAIL rst_mid_rfc got=%h exp=%h ref_seen=%0d", rst_vec, RST_EXP, seen);
    end
    bus_gnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_init("after_rfc_rst");
  endtask

  task automatic test_rst_mid_mrs1();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 100 && n < E_MR2 + TM + 2; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rst_vec !== RST_EXP) begin
      bad++; $display("FAIL rst_mid_mrs1 got=%h exp=%h", rst_vec, RST_EXP);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_init("after_mrs1_rst");
  endtask

  initial begin
    test_reset();
    test_init("power_up");
    test_gnt_high();
    test_postpone5();
    test_saturate();
    test_coincide();
    test_rst_mid_rfc();
    test_rst_mid_mrs1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
